multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the MIPS32 core. Walks each instruction through FETCH, DECODE, EXEC, MEM and WB states. In each state it drives the enables for the PC, the instruction register, the register-file decode/write-back stage (RegWrite, RegDst, MemtoReg, Jal), the ALU operand select and data memory. It sits between the instruction register and the datapath, replacing single-cycle control, and stalls on a data-memory ready handshake.

## Interface
Parameters:
- RESET_STATE, 3'd0, encoding loaded on reset (FETCH).

Ports:
- clock  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  permits a new fetch; sampled only in FETCH
- Instruction  in  32  current IR contents; stable from DECODE until return to FETCH
- Zero  in  1  ALU zero flag; valid in EXEC
- mem_ready  in  1  data memory done; sampled in MEM
- PCWrite  out  1  load PC this cycle
- PCSource  out  2  00 pc+4, 01 branch target, 10 jump target, 11 read_data_1 (jr)
- IRWrite  out  1  load instruction register
- ALUSrc  out  1  1 = sign/zero-extended immediate as ALU operand B
- MemRead  out  1  data memory read strobe
- MemWrite  out  1  data memory write strobe
- RegWrite  out  1  register-file write enable
- RegDst  out  1  1 = rd (Instruction[15:11]) is destination
- MemtoReg  out  1  1 = write-back data from memory
- Jal  out  1  1 = write pc+4 to register 31
- illegal  out  1  one-cycle pulse on unsupported opcode/funct
- state  out  3  current state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB
- retired  out  32  count of completed instructions

## Operation
- Decode key: op = Instruction[31:26], funct = Instruction[5:0].
  - R-type: op 000000; jr is R-type with funct 001000.
  - I-ALU: op 001xxx.
  - lw 100011; sw 101011; beq 000100; bne 000101; j 000010; jal 000011.
- FETCH: if run=1, assert IRWrite=1, PCWrite=1 and PCSource=00, then go to DECODE. If run=0, stay in FETCH with all outputs 0.
- DECODE:
  - j: PCWrite=1, PCSource=10, retire, go to FETCH.
  - jal: PCWrite=1, PCSource=10, go to WB.
  - illegal op, or R-type with unsupported funct: illegal=1, retire, go to FETCH. Supported funct values are add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, xor 100110, nor 100111, slt 101010, sltu 101011, sll 000000, srl 000010, sra 000011, jr 001000.
  - otherwise go to EXEC.
- EXEC:
  - ALUSrc=1 for I-ALU, lw and sw.
  - R-type/I-ALU: go to WB.
  - lw/sw: go to MEM.
  - beq: PCWrite=Zero, PCSource=01, retire, go to FETCH.
  - bne: PCWrite=~Zero, PCSource=01, retire, go to FETCH.
  - jr: PCWrite=1, PCSource=11, retire, go to FETCH.
- MEM: MemRead=1 (lw) or MemWrite=1 (sw) while mem_ready=0; stay in MEM. When mem_ready=1, the strobe is still high that cycle.
  - lw: go to WB.
  - sw: retire, go to FETCH.
- WB: RegWrite=1 for exactly one cycle, then retire and go to FETCH.
  - RegDst=1 for R-type.
  - MemtoReg=1 for lw.
  - Jal=1 for jal.
  - All other combinations have these bits at 0.
- RegDst, MemtoReg and Jal are 0 outside WB, and are never asserted together with a conflicting value (RegDst and Jal are mutually exclusive).
- Outputs are a Moore decode of the state register plus Instruction. Exceptions: the branch PCWrite depends on Zero, and the MEM→next-state transition depends on mem_ready.
- retired increments by 1 on every transition into FETCH from another state, and wraps 0xFFFFFFFF→0.
- State encodings 5–7 are unreachable; if entered, go to FETCH with all outputs 0 and no retire.

## Timing
- Reset: on a reset edge, state=FETCH and retired=0. All strobes and illegal are 0 from that edge until run is sampled.
- Reset mid-instruction (any state, including MEM with a strobe active): the instruction is abandoned with no retire. Strobes drop in the cycle after the reset edge. Reset has priority over every transition.
- Latency in cycles, FETCH to next FETCH, with zero memory wait:
  - j: 2
  - beq/bne/jr/jal: 3
  - R-type/I-ALU/sw: 4
  - lw: 5
  - Each cycle with mem_ready=0 in MEM adds 1.
- mem_ready=1 on the first MEM cycle means no wait. mem_ready is ignored outside MEM.
- run=0 only holds in FETCH and never interrupts an instruction in flight.

## Test plan
- Reset then run=1 with R-type add $3,$1,$2 (0x00221820): states 0,1,2,4,0. RegWrite=1 and RegDst=1 only in cycle 4. retired=1.
- lw $5,8($0) (0x8C050008) with mem_ready low for 2 MEM cycles: MemRead high for 3 cycles, then WB with MemtoReg=1. Total 7 cycles; retired increments once.
- beq with Zero=1, then bne with Zero=1: beq gives PCWrite=1, PCSource=01 in EXEC; bne gives PCWrite=0. Each takes 3 cycles; no RegWrite.
- jal (0x0C000010): DECODE has PCWrite=1, PCSource=10. WB has Jal=1, RegWrite=1, RegDst=0. 3 cycles.
- Illegal op 0xFC000000: illegal pulses 1 cycle in DECODE, back to FETCH, retired+1, no RegWrite or memory strobe.
- sw in MEM with mem_ready=0, reset asserted: next cycle state=0, MemWrite=0, retired=0. Then run=0 holds FETCH with IRWrite=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Sequencing controller for a multi-cycle MIPS32 datapath. Every instruction
// is walked through FETCH -> DECODE -> EXEC -> MEM -> WB. States are skipped
// where the instruction class does not need them. The controller holds in MEM
// until the data memory raises mem_ready.
//
// Control outputs are decoded from the state register and the instruction
// register contents. Three inputs also feed the decode directly:
//   - run gates the fetch strobes in FETCH,
//   - Zero selects whether a branch loads the PC,
//   - mem_ready decides when MEM may be left.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   run          permits a new fetch (only looked at in FETCH)
//   Instruction  instruction register contents, stable from DECODE onward
//   Zero         ALU zero flag, meaningful in EXEC
//   mem_ready    data memory completion, meaningful in MEM
//   PCWrite      load the PC this cycle
//   PCSource     PC source: 00 pc+4, 01 branch, 10 jump, 11 rs (jr)
//   IRWrite      load the instruction register
//   ALUSrc       1 = extended immediate is ALU operand B
//   MemRead      data memory read strobe
//   MemWrite     data memory write strobe
//   RegWrite     register file write enable
//   RegDst       1 = rd field is the destination register
//   MemtoReg     1 = write-back data comes from memory
//   Jal          1 = write pc+4 to $31
//   illegal      one-cycle pulse on an unsupported opcode/funct
//   state        current state (0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB)
//   retired      count of completed instructions, wraps at 2^32
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] Instruction,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic [1:0]  PCSource,
  output logic        IRWrite,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        Jal,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  logic [5:0] op;
  logic [5:0] funct;
  logic       is_rtype;
  logic       funct_ok;
  logic       is_jr;
  logic       is_ialu;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_bne;
  logic       is_j;
  logic       is_jal;
  logic       is_illegal;

  // Only the opcode and funct fields steer control; register and immediate
  // fields are consumed by the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instruction[25:6];

  assign op    = Instruction[31:26];
  assign funct = Instruction[5:0];

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,  // add addu sub subu
      6'b100100, 6'b100101, 6'b100110, 6'b100111,  // and or xor nor
      6'b101010, 6'b101011,                        // slt sltu
      6'b000000, 6'b000010, 6'b000011,             // sll srl sra
      FN_JR:                                       // jr
        funct_ok = 1'b1;
      default:
        funct_ok = 1'b0;
    endcase
  end

  assign is_rtype = (op == OP_RTYPE);
  assign is_jr    = is_rtype && (funct == FN_JR);
  // All eight 001xxx opcodes (addi .. lui) share the immediate-ALU path.
  assign is_ialu  = (op[5:3] == 3'b001);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = (op == OP_BNE);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);

  assign is_illegal = !((is_rtype && funct_ok) || is_ialu || is_lw || is_sw ||
                        is_beq || is_bne || is_j || is_jal);

  // ---------------------------------------------------------------------------
  // State and retire counter
  // ---------------------------------------------------------------------------
  state_e      state_q;
  state_e      state_d;
  logic [31:0] retired_q;
  logic [31:0] retired_d;
  logic        retire;

  // ---------------------------------------------------------------------------
  // Output decode and next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    PCWrite  = 1'b0;
    PCSource = PC_SEQ;
    IRWrite  = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    Jal      = 1'b0;
    illegal  = 1'b0;
    retire   = 1'b0;
    state_d  = state_q;

    case (state_q)
      S_FETCH: begin
        if (run) begin
          IRWrite  = 1'b1;
          PCWrite  = 1'b1;
          PCSource = PC_SEQ;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_j) begin
          PCWrite  = 1'b1;
          PCSource = PC_JUMP;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_jal) begin
          // The PC is redirected now. The link register is written in WB
          // from the pc+4 value already captured during FETCH.
          PCWrite  = 1'b1;
          PCSource = PC_JUMP;
          state_d  = S_WB;
        end else if (is_illegal) begin
          illegal  = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_EXEC;
        end
      end

      S_EXEC: begin
        ALUSrc = is_ialu || is_lw || is_sw;
        if (is_beq) begin
          PCWrite  = Zero;
          PCSource = PC_BRANCH;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_bne) begin
          PCWrite  = !Zero;
          PCSource = PC_BRANCH;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_jr) begin
          PCWrite  = 1'b1;
          PCSource = PC_REG;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d  = S_MEM;
        end else begin
          // Remaining legal classes here are R-type ALU and I-ALU.
          state_d  = S_WB;
        end
      end

      S_MEM: begin
        // The strobe stays up through the cycle in which mem_ready is seen.
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = is_rtype;
        MemtoReg = is_lw;
        Jal      = is_jal;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      default: begin
        // Encodings 5..7: recover to FETCH silently, nothing retires.
        state_d = S_FETCH;
      end
    endcase
  end

  assign retired_d = retire ? (retired_q + 32'd1) : retired_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= state_e'(RESET_STATE);
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for multicycle_ctrl. Each instruction is expanded into the
// per-cycle list of expected outputs implied by its class, then replayed
// against the DUT one cycle at a time.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic        clock;
  logic        reset;
  logic        run;
  logic [31:0] Instruction;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite;
  logic [1:0]  PCSource;
  logic        IRWrite;
  logic        ALUSrc;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic        Jal;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] retired;

  multicycle_ctrl #(.RESET_STATE(3'd0)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .Instruction (Instruction),
    .Zero        (Zero),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCSource    (PCSource),
    .IRWrite     (IRWrite),
    .ALUSrc      (ALUSrc),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .Jal         (Jal),
    .illegal     (illegal),
    .state       (state),
    .retired     (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed output word: {state, PCWrite, PCSource, IRWrite, ALUSrc, MemRead,
  // MemWrite, RegWrite, RegDst, MemtoReg, Jal, illegal}
  logic [14:0] obs;
  assign obs = {state, PCWrite, PCSource, IRWrite, ALUSrc, MemRead, MemWrite,
                RegWrite, RegDst, MemtoReg, Jal, illegal};

  localparam logic [14:0] M_ILL  = 15'h0001;
  localparam logic [14:0] M_JAL  = 15'h0002;
  localparam logic [14:0] M_M2R  = 15'h0004;
  localparam logic [14:0] M_RDST = 15'h0008;
  localparam logic [14:0] M_RW   = 15'h0010;
  localparam logic [14:0] M_MW   = 15'h0020;
  localparam logic [14:0] M_MR   = 15'h0040;
  localparam logic [14:0] M_ALUS = 15'h0080;
  localparam logic [14:0] M_IRW  = 15'h0100;
  localparam logic [14:0] M_PCW  = 15'h0800;

  localparam int C_RALU = 0;
  localparam int C_JR   = 1;
  localparam int C_IALU = 2;
  localparam int C_LW   = 3;
  localparam int C_SW   = 4;
  localparam int C_BEQ  = 5;
  localparam int C_BNE  = 6;
  localparam int C_J    = 7;
  localparam int C_JAL  = 8;
  localparam int C_ILL  = 9;

  typedef struct packed {
    logic [14:0] exp;
    logic        mr_fixed;  // mem_ready is dictated for this cycle
    logic        mr;
  } step_t;

  step_t       trace_q[$];
  int          n_cmp;
  int          n_err;
  logic [31:0] exp_ret;

  function automatic logic [14:0] st_f(input int s);
    return 15'(s) << 12;
  endfunction

  function automatic logic [14:0] pcs_f(input int p);
    return 15'(p) << 9;
  endfunction

  // Instruction class from the opcode/funct tables.
  function automatic int classify(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'd0) begin
      case (fn)
        6'b001000: return C_JR;
        6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
        6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
        6'b000011: return C_RALU;
        default:   return C_ILL;
      endcase
    end
    if (op[5:3] == 3'b001) return C_IALU;
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000101: return C_BNE;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic void push(input logic [14:0] e, input logic fixed, input logic mr);
    step_t s;
    s.exp      = e;
    s.mr_fixed = fixed;
    s.mr       = mr;
    trace_q.push_back(s);
  endfunction

  // Expected cycle-by-cycle outputs, FETCH up to (not including) the next FETCH.
  function automatic void build_trace(input logic [31:0] ins, input logic z, input int waits);
    int c;
    c = classify(ins);
    trace_q.delete();
    push(st_f(0) | M_PCW | M_IRW | pcs_f(0), 1'b0, 1'b0);
    if (c == C_J) begin
      push(st_f(1) | M_PCW | pcs_f(2), 1'b0, 1'b0);
    end else if (c == C_JAL) begin
      push(st_f(1) | M_PCW | pcs_f(2), 1'b0, 1'b0);
      push(st_f(4) | M_RW | M_JAL, 1'b0, 1'b0);
    end else if (c == C_ILL) begin
      push(st_f(1) | M_ILL, 1'b0, 1'b0);
    end else begin
      push(st_f(1), 1'b0, 1'b0);
      case (c)
        C_BEQ:  push(st_f(2) | (z ? M_PCW : 15'd0) | pcs_f(1), 1'b0, 1'b0);
        C_BNE:  push(st_f(2) | (z ? 15'd0 : M_PCW) | pcs_f(1), 1'b0, 1'b0);
        C_JR:   push(st_f(2) | M_PCW | pcs_f(3), 1'b0, 1'b0);
        C_RALU: begin
          push(st_f(2), 1'b0, 1'b0);
          push(st_f(4) | M_RW | M_RDST, 1'b0, 1'b0);
        end
        C_IALU: begin
          push(st_f(2) | M_ALUS, 1'b0, 1'b0);
          push(st_f(4) | M_RW, 1'b0, 1'b0);
        end
        C_LW: begin
          push(st_f(2) | M_ALUS, 1'b0, 1'b0);
          for (int w = 0; w < waits; w++) push(st_f(3) | M_MR, 1'b1, 1'b0);
          push(st_f(3) | M_MR, 1'b1, 1'b1);
          push(st_f(4) | M_RW | M_M2R, 1'b0, 1'b0);
        end
        default: begin  // sw
          push(st_f(2) | M_ALUS, 1'b0, 1'b0);
          for (int w = 0; w < waits; w++) push(st_f(3) | M_MW, 1'b1, 1'b0);
          push(st_f(3) | M_MW, 1'b1, 1'b1);
        end
      endcase
    end
  endfunction

  function automatic logic [5:0] pick_funct(input int k);
    case (k)
      0: return 6'b100000;  1: return 6'b100001;  2: return 6'b100010;
      3: return 6'b100011;  4: return 6'b100100;  5: return 6'b100101;
      6: return 6'b100110;  7: return 6'b100111;  8: return 6'b101010;
      9: return 6'b101011; 10: return 6'b000000; 11: return 6'b000010;
      default: return 6'b000011;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    int k;
    k = $urandom_range(0, 9);
    ins = $urandom;
    case (k)
      0: ins = {6'b000000, ins[25:6], pick_funct($urandom_range(0, 12))};
      1: ins = {6'b000000, ins[25:6], 6'b001000};
      2: ins = {3'b001, ins[28:0]};
      3: ins = {6'b100011, ins[25:0]};
      4: ins = {6'b101011, ins[25:0]};
      5: ins = {6'b000100, ins[25:0]};
      6: ins = {6'b000101, ins[25:0]};
      7: ins = {6'b000010, ins[25:0]};
      8: ins = {6'b000011, ins[25:0]};
      default: begin
        while (classify(ins) != C_ILL) ins = $urandom;
      end
    endcase
    return ins;
  endfunction

  task automatic chk_vec(input logic [14:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: outputs observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (retired === exp) else begin
      n_err++;
      $error("FAIL %s: retired observed %0d expected %0d", tag, retired, exp);
    end
  endtask

  // One clock cycle: drive just after the edge, sample mid-cycle.
  task automatic cyc(input logic r, input logic [31:0] ins, input logic z,
                     input logic mr, input logic [14:0] exp, input string tag);
    @(posedge clock);
    #1;
    run         = r;
    Instruction = ins;
    Zero        = z;
    mem_ready   = mr;
    #3;
    chk_vec(exp, tag);
    chk_ret(exp_ret, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 15'd0, "idle");
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic z, input int waits);
    string tag;
    logic  r;
    logic  mr;
    build_trace(ins, z, waits);
    for (int i = 0; i < trace_q.size(); i++) begin
      tag = $sformatf("ins %08h cyc %0d", ins, i);
      r   = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      mr  = trace_q[i].mr_fixed ? trace_q[i].mr : 1'($urandom_range(0, 1));
      cyc(r, (i == 0) ? $urandom : ins, z, mr, trace_q[i].exp, tag);
    end
    exp_ret = exp_ret + 32'd1;
    $display("instr %08h zero=%0d waits=%0d cycles=%0d retired_exp=%0d",
             ins, z, waits, trace_q.size(), exp_ret);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    exp_ret     = 32'd0;
    reset       = 1'b1;
    run         = 1'b0;
    Instruction = 32'd0;
    Zero        = 1'b0;
    mem_ready   = 1'b0;

    // Reset state
    @(posedge clock);
    #1;
    reset = 1'b0;
    #3;
    chk_vec(15'd0, "reset_state");
    chk_ret(32'd0, "reset_retired");
    idle(2);

    // Directed instructions
    run_instr(32'h00221820, 1'b0, 0);  // add $3,$1,$2
    run_instr(32'h8C050008, 1'b0, 2);  // lw with two wait cycles
    run_instr(32'h10220004, 1'b1, 0);  // beq, taken
    run_instr(32'h14220004, 1'b1, 0);  // bne, not taken
    run_instr(32'h14220004, 1'b0, 0);  // bne, taken
    run_instr(32'h0C000010, 1'b0, 0);  // jal
    run_instr(32'hFC000000, 1'b0, 0);  // illegal opcode
    run_instr(32'h0022183F, 1'b0, 0);  // R-type with bad funct
    run_instr(32'h08000010, 1'b0, 0);  // j
    run_instr(32'h03E00008, 1'b0, 0);  // jr $31
    run_instr(32'hAC050008, 1'b0, 1);  // sw with one wait
    run_instr(32'h20420001, 1'b0, 0);  // addi
    run_instr(32'h00000000, 1'b0, 0);  // sll nop
    idle(1);

    // Randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      idle($urandom_range(0, 2));
      run_instr(gen_instr(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Reset while sw is waiting in MEM
    cyc(1'b1, 32'd0, 1'b0, 1'b0, M_PCW | M_IRW, "rst_fetch");
    cyc(1'b0, 32'hAC050008, 1'b0, 1'b0, st_f(1), "rst_decode");
    cyc(1'b0, 32'hAC050008, 1'b0, 1'b0, st_f(2) | M_ALUS, "rst_exec");
    @(posedge clock);
    #1;
    run         = 1'b0;
    Instruction = 32'hAC050008;
    mem_ready   = 1'b0;
    reset       = 1'b1;
    #3;
    chk_vec(st_f(3) | M_MW, "rst_mem");
    chk_ret(exp_ret, "rst_mem");
    @(posedge clock);
    #1;
    reset   = 1'b0;
    run     = 1'b0;
    exp_ret = 32'd0;
    #3;
    chk_vec(15'd0, "rst_after");
    chk_ret(32'd0, "rst_after");
    $display("reset in MEM: state=%0d MemWrite=%0d retired=%0d", state, MemWrite, retired);
    idle(3);
    run_instr(32'h00221820, 1'b0, 0);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
